// File: rtl/mono_video_gen.sv
// mono_video_gen
// Turns a core's per-pixel colour code plus its blanking/sync strobes into a
// monochrome luma stream with matching, equally delayed timing outputs, and
// measures the visible area (pixels per line, lines per frame) of the result.
//
// Ports
//   clk_sys                  sole clock
//   reset                    synchronous, active-high
//   video_code               core pixel code (IN_W bits)
//   hblank_i/vblank_i/hs_i/vs_i  core timing, sampled on ce_pix cycles
//   invert                   1 = luma XOR all-ones on active pixels
//   pal_wr/pal_addr/pal_data palette write port, usable on any cycle
//   ce_pix                   one-cycle pixel enable every CE_DIV cycles
//   luma                     pixel level (OUT_W bits), 0 during blanking
//   hblank_o/vblank_o/hs_o/vs_o  timing delayed to line up with luma
//   de_o                     display enable, ~(hblank_o | vblank_o)
//   act_w/act_h              last measured active width / height
//   meas_valid               set by the first completed frame, cleared by reset
//
// Timing: inputs are sampled on the clk_sys edge that ends a ce_pix-high
// cycle (a "tick"). They travel through PIPE stages; the output registers
// take the last stage on a later tick, so an input sampled on tick n shows up
// on the outputs from tick n+PIPE onward.

module mono_video_gen #(
    parameter int CE_DIV = 8,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 8,
    parameter int PIPE   = 1
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [IN_W-1:0]  video_code,
    input  logic             hblank_i,
    input  logic             vblank_i,
    input  logic             hs_i,
    input  logic             vs_i,
    input  logic             invert,
    input  logic             pal_wr,
    input  logic [IN_W-1:0]  pal_addr,
    input  logic [OUT_W-1:0] pal_data,
    output logic             ce_pix,
    output logic [OUT_W-1:0] luma,
    output logic             hblank_o,
    output logic             vblank_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             de_o,
    output logic [11:0]      act_w,
    output logic [11:0]      act_h,
    output logic             meas_valid
);

    localparam int          CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int          DEPTH = 1 << IN_W;
    localparam logic [11:0] SAT   = 12'hFFF;

    // ------------------------------------------------------------------
    // Pixel-enable divider
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt    <= '0;
            ce_pix <= 1'b0;
        end else begin
            ce_pix <= (cnt == '0);
            if (cnt == CNT_W'(CE_DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Palette: linear grey ramp after reset, rewritable on any cycle.
    // The lookup below reads the registered array, so a write landing on
    // the same edge as a lookup of that entry returns the old contents.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] pal [DEPTH];

    function automatic logic [OUT_W-1:0] ramp_entry(input int idx);
        return OUT_W'((idx * ((1 << OUT_W) - 1)) / (DEPTH - 1));
    endfunction

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal[i] <= ramp_entry(i);
            end
        end else if (pal_wr) begin
            pal[pal_addr] <= pal_data;
        end
    end

    // ------------------------------------------------------------------
    // Alignment pipeline, advanced only on ticks
    // ------------------------------------------------------------------
    logic [IN_W-1:0] code_pipe [PIPE];
    logic [PIPE-1:0] hb_pipe;
    logic [PIPE-1:0] vb_pipe;
    logic [PIPE-1:0] hs_pipe;
    logic [PIPE-1:0] vs_pipe;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                code_pipe[i] <= '0;
            end
            hb_pipe <= '0;
            vb_pipe <= '0;
            hs_pipe <= '0;
            vs_pipe <= '0;
        end else if (ce_pix) begin
            code_pipe[0] <= video_code;
            hb_pipe[0]   <= hblank_i;
            vb_pipe[0]   <= vblank_i;
            hs_pipe[0]   <= hs_i;
            vs_pipe[0]   <= vs_i;
            for (int i = 1; i < PIPE; i++) begin
                code_pipe[i] <= code_pipe[i-1];
                hb_pipe[i]   <= hb_pipe[i-1];
                vb_pipe[i]   <= vb_pipe[i-1];
                hs_pipe[i]   <= hs_pipe[i-1];
                vs_pipe[i]   <= vs_pipe[i-1];
            end
        end
    end

    logic [IN_W-1:0] code_d;
    logic            hb_d;
    logic            vb_d;
    logic            hs_d;
    logic            vs_d;
    logic            de_n;

    assign code_d = code_pipe[PIPE-1];
    assign hb_d   = hb_pipe[PIPE-1];
    assign vb_d   = vb_pipe[PIPE-1];
    assign hs_d   = hs_pipe[PIPE-1];
    assign vs_d   = vs_pipe[PIPE-1];
    assign de_n   = ~(hb_d | vb_d);

    // ------------------------------------------------------------------
    // Output registers. de_o comes out of reset high because the cleared
    // pipeline carries "not blanking" until real samples arrive.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            luma     <= '0;
            hblank_o <= 1'b0;
            vblank_o <= 1'b0;
            hs_o     <= 1'b0;
            vs_o     <= 1'b0;
            de_o     <= 1'b1;
        end else if (ce_pix) begin
            luma     <= de_n ? (pal[code_d] ^ {OUT_W{invert}}) : '0;
            hblank_o <= hb_d;
            vblank_o <= vb_d;
            hs_o     <= hs_d;
            vs_o     <= vs_d;
            de_o     <= de_n;
        end
    end

    // ------------------------------------------------------------------
    // Active-area measurement, evaluated on ticks.
    // A tick counts as a pixel when the de_o period it closes was active,
    // so the tick on which de_o falls still adds the final pixel of the
    // line. A line ending on the same tick vblank_o rises is counted into
    // that frame's height.
    // ------------------------------------------------------------------
    logic [11:0] pix_cnt;
    logic [11:0] line_cnt;
    logic [11:0] pix_total;
    logic [11:0] line_total;
    logic        de_fall;
    logic        vb_rise;

    always_comb begin
        de_fall    = de_o & ~de_n;
        vb_rise    = ~vblank_o & vb_d;
        pix_total  = pix_cnt;
        if (de_o && (pix_cnt != SAT)) begin
            pix_total = pix_cnt + 12'd1;
        end
        line_total = line_cnt;
        if (de_fall && (line_cnt != SAT)) begin
            line_total = line_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pix_cnt    <= '0;
            line_cnt   <= '0;
            act_w      <= '0;
            act_h      <= '0;
            meas_valid <= 1'b0;
        end else if (ce_pix) begin
            if (de_fall) begin
                act_w   <= pix_total;
                pix_cnt <= '0;
            end else begin
                pix_cnt <= pix_total;
            end
            if (vb_rise) begin
                act_h      <= line_total;
                line_cnt   <= '0;
                meas_valid <= 1'b1;
            end else begin
                line_cnt <= line_total;
            end
        end
    end

endmodule
